// File: rtl/wb_arbiter2.sv
// Two-master to one-slave Wishbone B4 pipelined arbiter with round-robin grant per bus cycle.
// Outstanding requests are tracked so late acks are swallowed rather than routed to the wrong master.
module wb_arbiter2 #(
  parameter int unsigned G_ADDR_SIZE    = 8,
  parameter int unsigned G_DATA_SIZE    = 16,
  parameter int unsigned G_DRAIN_CYCLES = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   s0_wb_cyc_i,
  input  logic                   s0_wb_stb_i,
  output logic                   s0_wb_stall_o,
  output logic                   s0_wb_ack_o,
  input  logic                   s0_wb_we_i,
  input  logic [G_ADDR_SIZE-1:0] s0_wb_addr_i,
  input  logic [G_DATA_SIZE-1:0] s0_wb_data_i,
  output logic [G_DATA_SIZE-1:0] s0_wb_data_o,
  input  logic                   s1_wb_cyc_i,
  input  logic                   s1_wb_stb_i,
  output logic                   s1_wb_stall_o,
  output logic                   s1_wb_ack_o,
  input  logic                   s1_wb_we_i,
  input  logic [G_ADDR_SIZE-1:0] s1_wb_addr_i,
  input  logic [G_DATA_SIZE-1:0] s1_wb_data_i,
  output logic [G_DATA_SIZE-1:0] s1_wb_data_o,
  output logic                   m_wb_cyc_o,
  output logic                   m_wb_stb_o,
  input  logic                   m_wb_stall_i,
  input  logic                   m_wb_ack_i,
  output logic                   m_wb_we_o,
  output logic [G_ADDR_SIZE-1:0] m_wb_addr_o,
  output logic [G_DATA_SIZE-1:0] m_wb_data_o,
  input  logic [G_DATA_SIZE-1:0] m_wb_data_i
);

  localparam int unsigned CNT_W      = 4;
  localparam int unsigned DRAIN_W    = (G_DRAIN_CYCLES < 2) ? 1 : $clog2(G_DRAIN_CYCLES + 1);
  localparam logic [CNT_W-1:0]   CNT_MAX    = CNT_W'(15);
  localparam logic [DRAIN_W-1:0] DRAIN_LOAD = DRAIN_W'(G_DRAIN_CYCLES);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GNT0  = 2'd1,
    ST_GNT1  = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic               last_grant_q, last_grant_d;
  logic [CNT_W-1:0]   outstanding_q, outstanding_d;
  logic [DRAIN_W-1:0] drain_cnt_q, drain_cnt_d;

  logic sat;
  logic req_acc;
  logic ack_cnt;
  logic fwd_ack;

  // A full counter blocks further strobes from reaching the slave.
  assign sat     = (outstanding_q == CNT_MAX);
  assign req_acc = m_wb_cyc_o & m_wb_stb_o & ~m_wb_stall_i;
  assign ack_cnt = m_wb_ack_i & (state_q != ST_IDLE) & (outstanding_q != '0);
  assign fwd_ack = m_wb_ack_i & ((state_q == ST_GNT0) | (state_q == ST_GNT1));

  // Datapath steering: granted master passes straight through, everyone else is stalled.
  always_comb begin
    m_wb_cyc_o    = 1'b0;
    m_wb_stb_o    = 1'b0;
    m_wb_we_o     = 1'b0;
    m_wb_addr_o   = '0;
    m_wb_data_o   = '0;
    s0_wb_stall_o = 1'b1;
    s0_wb_ack_o   = 1'b0;
    s0_wb_data_o  = '0;
    s1_wb_stall_o = 1'b1;
    s1_wb_ack_o   = 1'b0;
    s1_wb_data_o  = '0;
    case (state_q)
      ST_GNT0: begin
        m_wb_cyc_o    = s0_wb_cyc_i;
        m_wb_stb_o    = s0_wb_stb_i & ~sat;
        m_wb_we_o     = s0_wb_we_i;
        m_wb_addr_o   = s0_wb_addr_i;
        m_wb_data_o   = s0_wb_data_i;
        s0_wb_stall_o = m_wb_stall_i | sat;
        s0_wb_ack_o   = m_wb_ack_i;
        s0_wb_data_o  = m_wb_data_i;
      end
      ST_GNT1: begin
        m_wb_cyc_o    = s1_wb_cyc_i;
        m_wb_stb_o    = s1_wb_stb_i & ~sat;
        m_wb_we_o     = s1_wb_we_i;
        m_wb_addr_o   = s1_wb_addr_i;
        m_wb_data_o   = s1_wb_data_i;
        s1_wb_stall_o = m_wb_stall_i | sat;
        s1_wb_ack_o   = m_wb_ack_i;
        s1_wb_data_o  = m_wb_data_i;
      end
      default: ;
    endcase
  end

  // Arbitration, outstanding tracking and drain timeout.
  always_comb begin
    state_d       = state_q;
    last_grant_d  = last_grant_q;
    drain_cnt_d   = drain_cnt_q;
    outstanding_d = outstanding_q;

    if (req_acc && !ack_cnt) begin
      outstanding_d = outstanding_q + CNT_W'(1);
    end else if (!req_acc && ack_cnt) begin
      outstanding_d = outstanding_q - CNT_W'(1);
    end

    case (state_q)
      ST_IDLE: begin
        if (s0_wb_cyc_i && s1_wb_cyc_i) begin
          state_d = last_grant_q ? ST_GNT0 : ST_GNT1;
        end else if (s0_wb_cyc_i) begin
          state_d = ST_GNT0;
        end else if (s1_wb_cyc_i) begin
          state_d = ST_GNT1;
        end
      end
      ST_GNT0: begin
        if (!s0_wb_cyc_i) begin
          last_grant_d = 1'b0;
          if (outstanding_d != '0) begin
            state_d     = ST_DRAIN;
            drain_cnt_d = DRAIN_LOAD;
          end else if (s1_wb_cyc_i) begin
            state_d = ST_GNT1;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_GNT1: begin
        if (!s1_wb_cyc_i) begin
          last_grant_d = 1'b1;
          if (outstanding_d != '0) begin
            state_d     = ST_DRAIN;
            drain_cnt_d = DRAIN_LOAD;
          end else if (s0_wb_cyc_i) begin
            state_d = ST_GNT0;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_DRAIN: begin
        drain_cnt_d = (drain_cnt_q != '0) ? drain_cnt_q - DRAIN_W'(1) : '0;
        if ((outstanding_d == '0) || (drain_cnt_d == '0)) begin
          state_d       = ST_IDLE;
          outstanding_d = '0;
          drain_cnt_d   = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q       <= ST_IDLE;
      last_grant_q  <= 1'b1;
      outstanding_q <= '0;
      drain_cnt_q   <= '0;
    end else begin
      state_q       <= state_d;
      last_grant_q  <= last_grant_d;
      outstanding_q <= outstanding_d;
      drain_cnt_q   <= drain_cnt_d;
    end
  end

  // An ack handed to the owner must match a request it has issued.
  ack_never_exceeds_req: assert property (
    @(posedge clk_i) disable iff (rst_i)
    fwd_ack |-> ((outstanding_q != '0) || req_acc)
  );

endmodule

// File: tb/tb_wb_arbiter2.sv
// Directed bench for wb_arbiter2: a small memory slave with selectable ack latency sits behind the arbiter.
module tb_wb_arbiter2;

  localparam int unsigned AW = 8;
  localparam int unsigned DW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          s0_cyc, s0_stb, s0_we, s0_stall, s0_ack;
  logic [AW-1:0] s0_addr;
  logic [DW-1:0] s0_wdata, s0_rdata;
  logic          s1_cyc, s1_stb, s1_we, s1_stall, s1_ack;
  logic [AW-1:0] s1_addr;
  logic [DW-1:0] s1_wdata, s1_rdata;
  logic          m_cyc, m_stb, m_we, m_stall, m_ack;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata, m_rdata;

  int errors = 0;
  int checks = 0;

  logic [DW-1:0] mem [256];
  logic          mem_loaded = 1'b0;
  logic          v0, v1;
  logic [DW-1:0] d0, d1;
  logic          acc;
  int            lat  = 1;
  bit            mute = 1'b0;

  wb_arbiter2 #(.G_ADDR_SIZE(AW), .G_DATA_SIZE(DW), .G_DRAIN_CYCLES(4)) dut (
    .clk_i(clk), .rst_i(rst),
    .s0_wb_cyc_i(s0_cyc), .s0_wb_stb_i(s0_stb), .s0_wb_stall_o(s0_stall), .s0_wb_ack_o(s0_ack),
    .s0_wb_we_i(s0_we), .s0_wb_addr_i(s0_addr), .s0_wb_data_i(s0_wdata), .s0_wb_data_o(s0_rdata),
    .s1_wb_cyc_i(s1_cyc), .s1_wb_stb_i(s1_stb), .s1_wb_stall_o(s1_stall), .s1_wb_ack_o(s1_ack),
    .s1_wb_we_i(s1_we), .s1_wb_addr_i(s1_addr), .s1_wb_data_i(s1_wdata), .s1_wb_data_o(s1_rdata),
    .m_wb_cyc_o(m_cyc), .m_wb_stb_o(m_stb), .m_wb_stall_i(m_stall), .m_wb_ack_i(m_ack),
    .m_wb_we_o(m_we), .m_wb_addr_o(m_addr), .m_wb_data_o(m_wdata), .m_wb_data_i(m_rdata)
  );

  always #5 clk = ~clk;

  // Memory slave: ack after 1 or 2 cycles, optionally muted to leave requests orphaned.
  assign acc = m_cyc & m_stb & ~m_stall;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      v0 <= 1'b0; v1 <= 1'b0; d0 <= '0; d1 <= '0;
      if (!mem_loaded) begin
        for (int i = 0; i < 256; i++) mem[i] <= 16'hA000 + 16'(i);
        mem_loaded <= 1'b1;
      end
    end else begin
      v0 <= acc;
      d0 <= m_we ? '0 : mem[m_addr];
      v1 <= v0;
      d1 <= d0;
      if (acc && m_we) mem[m_addr] <= m_wdata;
    end
  end
  assign m_ack   = !mute && ((lat == 1) ? v0 : v1);
  assign m_rdata = (lat == 1) ? d0 : d1;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    s0_cyc = 1'b0; s0_stb = 1'b0; s0_we = 1'b0; s0_addr = '0; s0_wdata = '0;
    s1_cyc = 1'b0; s1_stb = 1'b0; s1_we = 1'b0; s1_addr = '0; s1_wdata = '0;
  endtask

  task automatic test_reset();
    idle_inputs();
    m_stall = 1'b0;
    rst = 1'b0;
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    checks++; if (m_cyc !== 1'b0) begin errors++; $display("FAIL rst_m_cyc: got %b want 0", m_cyc); end
    checks++; if (m_stb !== 1'b0) begin errors++; $display("FAIL rst_m_stb: got %b want 0", m_stb); end
    checks++; if (m_addr !== 8'h00) begin errors++; $display("FAIL rst_m_addr: got %h want 00", m_addr); end
    checks++; if (m_wdata !== 16'h0000) begin errors++; $display("FAIL rst_m_data: got %h want 0000", m_wdata); end
    checks++; if (s0_stall !== 1'b1) begin errors++; $display("FAIL rst_s0_stall: got %b want 1", s0_stall); end
    checks++; if (s1_stall !== 1'b1) begin errors++; $display("FAIL rst_s1_stall: got %b want 1", s1_stall); end
    checks++; if (s0_ack !== 1'b0) begin errors++; $display("FAIL rst_s0_ack: got %b want 0", s0_ack); end
    checks++; if (s1_ack !== 1'b0) begin errors++; $display("FAIL rst_s1_ack: got %b want 0", s1_ack); end
    checks++; if (s0_rdata !== 16'h0000) begin errors++; $display("FAIL rst_s0_data: got %h want 0000", s0_rdata); end
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_write_s0();
    step();
    s0_cyc = 1'b1; s0_stb = 1'b1; s0_we = 1'b1; s0_addr = 8'h10; s0_wdata = 16'h1234;
    #1;
    checks++; if (m_cyc !== 1'b0) begin errors++; $display("FAIL wr_arb_latency_mcyc: got %b want 0", m_cyc); end
    checks++; if (s0_stall !== 1'b1) begin errors++; $display("FAIL wr_arb_latency_stall: got %b want 1", s0_stall); end
    step();
    checks++; if (m_cyc !== 1'b1) begin errors++; $display("FAIL wr_m_cyc: got %b want 1", m_cyc); end
    checks++; if (m_stb !== 1'b1) begin errors++; $display("FAIL wr_m_stb: got %b want 1", m_stb); end
    checks++; if (m_we !== 1'b1) begin errors++; $display("FAIL wr_m_we: got %b want 1", m_we); end
    checks++; if (m_addr !== 8'h10) begin errors++; $display("FAIL wr_m_addr: got %h want 10", m_addr); end
    checks++; if (m_wdata !== 16'h1234) begin errors++; $display("FAIL wr_m_data: got %h want 1234", m_wdata); end
    checks++; if (s0_stall !== 1'b0) begin errors++; $display("FAIL wr_s0_stall: got %b want 0", s0_stall); end
    checks++; if (s1_stall !== 1'b1) begin errors++; $display("FAIL wr_s1_stall_gnt: got %b want 1", s1_stall); end
    step();
    s0_stb = 1'b0; s0_we = 1'b0;
    #1;
    checks++; if (s0_ack !== 1'b1) begin errors++; $display("FAIL wr_s0_ack: got %b want 1", s0_ack); end
    checks++; if (s1_ack !== 1'b0) begin errors++; $display("FAIL wr_s1_ack: got %b want 0", s1_ack); end
    checks++; if (s1_stall !== 1'b1) begin errors++; $display("FAIL wr_s1_stall_ack: got %b want 1", s1_stall); end
    step();
    s0_cyc = 1'b0;
    #1;
    checks++; if (s0_ack !== 1'b0) begin errors++; $display("FAIL wr_single_ack: got %b want 0", s0_ack); end
    step();
    checks++; if (s0_stall !== 1'b1) begin errors++; $display("FAIL wr_idle_stall: got %b want 1", s0_stall); end
    checks++; if (m_cyc !== 1'b0) begin errors++; $display("FAIL wr_idle_mcyc: got %b want 0", m_cyc); end
  endtask

  task automatic test_tie();
    step();
    rst = 1'b1;
    idle_inputs();
    s0_cyc = 1'b1; s1_cyc = 1'b1;
    #1;
    checks++; if (s0_stall !== 1'b1) begin errors++; $display("FAIL tie_rst_stall: got %b want 1", s0_stall); end
    step();
    rst = 1'b0;
    step();
    checks++; if (s0_stall !== 1'b0) begin errors++; $display("FAIL tie_s0_first_s0: got %b want 0", s0_stall); end
    checks++; if (s1_stall !== 1'b1) begin errors++; $display("FAIL tie_s0_first_s1: got %b want 1", s1_stall); end
    s0_cyc = 1'b0;
    #1;
    checks++; if (m_cyc !== 1'b0) begin errors++; $display("FAIL tie_drop_mcyc: got %b want 0", m_cyc); end
    step();
    checks++; if (s1_stall !== 1'b0) begin errors++; $display("FAIL tie_handoff_s1: got %b want 0", s1_stall); end
    checks++; if (m_cyc !== 1'b1) begin errors++; $display("FAIL tie_handoff_mcyc: got %b want 1", m_cyc); end
    s1_stb = 1'b1; s1_we = 1'b0; s1_addr = 8'h10;
    #1;
    checks++; if (m_addr !== 8'h10) begin errors++; $display("FAIL tie_rd_addr: got %h want 10", m_addr); end
    step();
    s1_stb = 1'b0;
    #1;
    checks++; if (s1_ack !== 1'b1) begin errors++; $display("FAIL tie_rd_ack: got %b want 1", s1_ack); end
    checks++; if (s1_rdata !== 16'h1234) begin errors++; $display("FAIL tie_rd_data: got %h want 1234", s1_rdata); end
    checks++; if (s0_ack !== 1'b0) begin errors++; $display("FAIL tie_s0_no_ack: got %b want 0", s0_ack); end
    checks++; if (s0_rdata !== 16'h0000) begin errors++; $display("FAIL tie_s0_no_data: got %h want 0000", s0_rdata); end
    step();
    s1_cyc = 1'b0;
    step();
    checks++; if (s1_stall !== 1'b1) begin errors++; $display("FAIL tie_idle_stall: got %b want 1", s1_stall); end
  endtask

  task automatic test_alternate();
    logic [3:0] exp_seq;
    exp_seq = 4'b1010;
    step();
    s0_cyc = 1'b1; s1_cyc = 1'b1; s0_addr = 8'hA0; s1_addr = 8'hB1;
    step();
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({s1_stall, s0_stall} !== (exp_seq[i] ? 2'b01 : 2'b10)) begin
        errors++; $display("FAIL alt_grant_%0d: got stall s1s0=%b%b want grant %0d", i, s1_stall, s0_stall, exp_seq[i]);
      end
      checks++;
      if (m_addr !== (exp_seq[i] ? 8'hB1 : 8'hA0)) begin
        errors++; $display("FAIL alt_addr_%0d: got %h want %h", i, m_addr, exp_seq[i] ? 8'hB1 : 8'hA0);
      end
      if (exp_seq[i]) s1_cyc = 1'b0; else s0_cyc = 1'b0;
      step();
      if (exp_seq[i]) s1_cyc = 1'b1; else s0_cyc = 1'b1;
      #1;
    end
    idle_inputs();
    step();
    step();
  endtask

  task automatic test_drain();
    lat = 2;
    step();
    s0_cyc = 1'b1; s0_stb = 1'b1; s0_we = 1'b0; s0_addr = 8'h00;
    step();
    step();
    s0_addr = 8'h01; s1_cyc = 1'b1;
    #1;
    step();
    s0_addr = 8'h02;
    #1;
    checks++; if (s0_ack !== 1'b1) begin errors++; $display("FAIL drn_ack0: got %b want 1", s0_ack); end
    checks++; if (s0_rdata !== 16'hA000) begin errors++; $display("FAIL drn_data0: got %h want A000", s0_rdata); end
    checks++; if (s1_ack !== 1'b0) begin errors++; $display("FAIL drn_s1_ack0: got %b want 0", s1_ack); end
    step();
    s0_cyc = 1'b0; s0_stb = 1'b0;
    #1;
    checks++; if (s0_ack !== 1'b1) begin errors++; $display("FAIL drn_ack1: got %b want 1", s0_ack); end
    checks++; if (s0_rdata !== 16'hA001) begin errors++; $display("FAIL drn_data1: got %h want A001", s0_rdata); end
    checks++; if (dut.outstanding_q !== 4'd2) begin errors++; $display("FAIL drn_outstanding: got %0d want 2", dut.outstanding_q); end
    step();
    checks++; if (s1_ack !== 1'b0) begin errors++; $display("FAIL drn_swallow_s1: got %b want 0", s1_ack); end
    checks++; if (s0_ack !== 1'b0) begin errors++; $display("FAIL drn_swallow_s0: got %b want 0", s0_ack); end
    checks++; if (s1_rdata !== 16'h0000) begin errors++; $display("FAIL drn_s1_data: got %h want 0000", s1_rdata); end
    checks++; if (s1_stall !== 1'b1) begin errors++; $display("FAIL drn_s1_stall: got %b want 1", s1_stall); end
    checks++; if (m_cyc !== 1'b0) begin errors++; $display("FAIL drn_mcyc: got %b want 0", m_cyc); end
    step();
    checks++; if (s1_stall !== 1'b1) begin errors++; $display("FAIL drn_idle_stall: got %b want 1", s1_stall); end
    checks++; if (dut.outstanding_q !== 4'd0) begin errors++; $display("FAIL drn_cleared: got %0d want 0", dut.outstanding_q); end
    step();
    checks++; if (s1_stall !== 1'b0) begin errors++; $display("FAIL drn_gnt1: got %b want 0", s1_stall); end
    checks++; if (m_cyc !== 1'b1) begin errors++; $display("FAIL drn_gnt1_mcyc: got %b want 1", m_cyc); end
    s1_cyc = 1'b0;
    step();
    lat = 1;
  endtask

  task automatic test_drain_timeout();
    step();
    mute = 1'b1;
    s0_cyc = 1'b1; s0_stb = 1'b1; s0_we = 1'b0; s0_addr = 8'h03;
    step();
    step();
    step();
    s0_cyc = 1'b0; s0_stb = 1'b0; s1_cyc = 1'b1;
    #1;
    checks++; if (dut.outstanding_q !== 4'd2) begin errors++; $display("FAIL to_outstanding: got %0d want 2", dut.outstanding_q); end
    for (int k = 0; k < 5; k++) begin
      step();
      checks++;
      if (s1_stall !== 1'b1) begin errors++; $display("FAIL to_stall_%0d: got %b want 1", k, s1_stall); end
      checks++;
      if (dut.outstanding_q !== ((k < 4) ? 4'd2 : 4'd0)) begin
        errors++; $display("FAIL to_count_%0d: got %0d want %0d", k, dut.outstanding_q, (k < 4) ? 2 : 0);
      end
    end
    step();
    checks++; if (s1_stall !== 1'b0) begin errors++; $display("FAIL to_gnt1: got %b want 0", s1_stall); end
    s1_cyc = 1'b0;
    step();
    mute = 1'b0;
  endtask

  task automatic test_reset_mid();
    step();
    mute = 1'b1;
    s1_cyc = 1'b1; s1_stb = 1'b1; s1_we = 1'b0; s1_addr = 8'h10;
    step();
    step();
    s1_stb = 1'b0; s0_cyc = 1'b1;
    #1;
    checks++; if (dut.outstanding_q !== 4'd1) begin errors++; $display("FAIL rm_pre_outstanding: got %0d want 1", dut.outstanding_q); end
    checks++; if (m_cyc !== 1'b1) begin errors++; $display("FAIL rm_pre_mcyc: got %b want 1", m_cyc); end
    #2 rst = 1'b1;
    #1;
    checks++; if (m_cyc !== 1'b0) begin errors++; $display("FAIL rm_m_cyc: got %b want 0", m_cyc); end
    checks++; if (m_addr !== 8'h00) begin errors++; $display("FAIL rm_m_addr: got %h want 00", m_addr); end
    checks++; if (s1_stall !== 1'b1) begin errors++; $display("FAIL rm_s1_stall: got %b want 1", s1_stall); end
    checks++; if (s0_stall !== 1'b1) begin errors++; $display("FAIL rm_s0_stall: got %b want 1", s0_stall); end
    checks++; if (s1_ack !== 1'b0) begin errors++; $display("FAIL rm_s1_ack: got %b want 0", s1_ack); end
    checks++; if (dut.outstanding_q !== 4'd0) begin errors++; $display("FAIL rm_outstanding: got %0d want 0", dut.outstanding_q); end
    @(posedge clk);
    #1 rst = 1'b0;
    step();
    checks++; if (s0_stall !== 1'b0) begin errors++; $display("FAIL rm_tie_s0: got %b want 0", s0_stall); end
    checks++; if (s1_stall !== 1'b1) begin errors++; $display("FAIL rm_tie_s1: got %b want 1", s1_stall); end
    mute = 1'b0;
    idle_inputs();
    step();
    step();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_write_s0();
    test_tie();
    test_alternate();
    test_drain();
    test_drain_timeout();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
